lzd_norm_seq: RTL and testbench
===============================

# lzd_norm_seq

Multi-cycle normalizer for 64-bit fixed-point operands in the Box-Muller AWGN datapath, placed ahead of the log and sqrt evaluation units. It shares one 32-bit leading-zero detector between the upper and lower halves of the operand and then left-shifts the operand so that its MSB is 1. It reports the leading-zero count and a zero flag. Valid/ready handshakes on both sides let it sit between the uniform RNG stage and the function units.

## Interface
- `W`, default 64: operand width. Fixed at 64; a second value is not supported.
- `SEG`, default 32: LZD segment width. Must equal W/2.
- `clk`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `in_valid`  in  1: operand offered.
- `in_ready`  out  1: block can accept an operand.
- `in_data`  in  64: operand, unsigned.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  64: normalized operand, `in_data << out_lzc`.
- `out_lzc`  out  7: leading-zero count, range 0..64.
- `out_zero`  out  1: operand was all zeros.

## Operation
- FSM states: IDLE, HI, LO, SHIFT, DONE. The state register is the only control state. An operand register `opnd[63:0]` and a count register `lzc[6:0]` hold the datapath.
- **IDLE**
  - `in_ready` = 1.
  - When `in_valid && in_ready`: `opnd <= in_data`, `out_zero <= 0`, next state HI.
- **HI**
  - LZD input = `opnd[63:32]`.
  - If v = 1: `lzc <= {2'b00, p}`, next state SHIFT.
  - Otherwise next state LO.
- **LO**
  - LZD input = `opnd[31:0]`.
  - If v = 1: `lzc <= 32 + p`, next state SHIFT.
  - Otherwise: `lzc <= 64`, `out_zero <= 1`, `opnd <= 0`, next state DONE.
- **SHIFT**: `opnd <= opnd << lzc[5:0]`, next state DONE.
- **DONE**
  - `out_valid` = 1. `out_data`, `out_lzc` and `out_zero` come from the registers and are stable.
  - When `out_ready` = 1: next state IDLE.
- `in_ready` = 1 only in IDLE. `out_valid` = 1 only in DONE. Both are decoded from registered state with no combinational path from inputs.
- LZD semantics:
  - p = number of leading zeros of the 32-bit segment, 0..31.
  - v = segment nonzero.
  - p is don't-care when v = 0.
- The LZD input multiplexer selects the upper half in HI and the lower half in every other state.

## Timing
- Reset, applied on any edge with `rst` = 1:
  - state = IDLE, `opnd` = 0, `lzc` = 0, `out_zero` = 0.
  - Outputs during reset: `in_ready` = 0 and `out_valid` = 0.
  - `in_ready` = 1 from the first cycle after `rst` deasserts.
- Acceptance cycle t is the cycle in which `in_valid && in_ready` is sampled. `out_valid` rises at:
  - upper half nonzero: cycle t+3 (HI, SHIFT, DONE);
  - upper half zero, lower half nonzero: cycle t+4 (HI, LO, SHIFT, DONE);
  - operand all zeros: cycle t+3 (HI, LO, DONE; no shift cycle).
- Output handshake: `out_valid` holds until `out_ready` is sampled high. Outputs stay unchanged while stalled.
- Back-to-back: after the output handshake completes, IDLE lasts at least one cycle. Peak throughput is one operand per 4 cycles; worst case is one per 5.
- `in_valid` outside IDLE is ignored and not captured.
- Reset during HI, LO, SHIFT or DONE abandons the operand: no `out_valid` pulse and no partial result.
- The LZD and shifter are single-cycle combinational paths. The shifter is a 64-bit barrel shifter with a 6-bit amount.

## Structure
- Shared package `bm_pkg`:
  - state enum `norm_state_t` {IDLE, HI, LO, SHIFT, DONE};
  - constants `NORM_W` = 64, `NORM_SEG` = 32, `LZC_W` = 7.
- One sub-module, `lzd32`:
  - purely combinational, `a[31:0]` in, `p[4:0]` and `v` out;
  - instantiated once, fed by the segment multiplexer.
- The top level holds the FSM, `opnd`/`lzc` registers, segment multiplexer and shifter.

## Test plan
- 0x8000_0000_0000_0000 with `out_ready` = 1 → at t+3: `out_lzc` = 0, `out_data` = 0x8000_0000_0000_0000, `out_zero` = 0.
- 0x0000_0001_2345_6789 → at t+3: `out_lzc` = 31, `out_data` = 0x91A2_B3C4_8000_0000.
- 0x0000_0000_0000_0001 → at t+4: `out_lzc` = 63, `out_data` = 0x8000_0000_0000_0000.
- 0x0 → at t+3: `out_lzc` = 64, `out_zero` = 1, `out_data` = 0.
- Backpressure: hold `out_ready` = 0 for 6 cycles after `out_valid` rises.
  - Outputs stay stable and `in_ready` = 0 throughout.
  - A second operand offered during the stall is not accepted until IDLE.
- Pulse `rst` in the LO state of the 0x1 operand → no `out_valid`; `in_ready` = 1 one cycle after reset. Then send 0x4000_0000_0000_0000 → `out_lzc` = 1.

Source files
------------

// File: rtl/bm_pkg.sv
// Shared types and constants for the Box-Muller datapath normalizer.
// Holds the normalizer FSM state enum and operand/segment/count widths.
package bm_pkg;

    localparam int NORM_W   = 64;
    localparam int NORM_SEG = 32;
    localparam int LZC_W    = 7;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        SHIFT,
        DONE
    } norm_state_t;

endpackage

// File: rtl/lzd_norm_seq_lzd32.sv
// 32-bit leading-zero detector, purely combinational.
// Ports: a (segment in), p (leading-zero count, valid when v), v (a != 0).
module lzd32 (
    input  logic [31:0] a,
    output logic [4:0]  p,
    output logic        v
);

    logic found;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        p     = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && a[i]) begin
                p     = 5'(31 - i);
                found = 1'b1;
            end
        end
        v = |a;
    end

endmodule

// File: rtl/lzd_norm_seq.sv
// Multi-cycle 64-bit normalizer: shared 32-bit LZD over both halves, then a
// barrel shift so the MSB is 1. Ports: clk, rst (sync, active-high),
// in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_lzc/out_zero.
module lzd_norm_seq
    import bm_pkg::*;
#(
    parameter int W   = NORM_W,
    parameter int SEG = NORM_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [LZC_W-1:0] out_lzc,
    output logic             out_zero
);

    norm_state_t      state, state_d;
    logic [W-1:0]     opnd, opnd_d;
    logic [LZC_W-1:0] lzc, lzc_d;
    logic             zero, zero_d;

    logic [SEG-1:0]   seg;
    logic [4:0]       p;
    logic             v;

    // Upper half only in HI; the lower half otherwise.
    assign seg = (state == HI) ? opnd[W-1:SEG] : opnd[SEG-1:0];

    lzd32 u_lzd (
        .a (seg),
        .p (p),
        .v (v)
    );

    // Handshake flags are forced low while reset is held.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;
    assign out_data  = opnd;
    assign out_lzc   = lzc;
    assign out_zero  = zero;

    always_comb begin
        state_d = state;
        opnd_d  = opnd;
        lzc_d   = lzc;
        zero_d  = zero;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    opnd_d  = in_data;
                    zero_d  = 1'b0;
                    state_d = HI;
                end
            end
            HI: begin
                if (v) begin
                    lzc_d   = {2'b00, p};
                    state_d = SHIFT;
                end else begin
                    state_d = LO;
                end
            end
            LO: begin
                if (v) begin
                    lzc_d   = LZC_W'(SEG) + {2'b00, p};
                    state_d = SHIFT;
                end else begin
                    // All-zero operand skips the shift cycle.
                    lzc_d   = LZC_W'(W);
                    zero_d  = 1'b1;
                    opnd_d  = '0;
                    state_d = DONE;
                end
            end
            SHIFT: begin
                opnd_d  = opnd << lzc[5:0];
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opnd  <= '0;
            lzc   <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_d;
            opnd  <= opnd_d;
            lzc   <= lzc_d;
            zero  <= zero_d;
        end
    end

endmodule

// File: tb/tb_lzd_norm_seq.sv
// Directed + scoreboard bench for lzd_norm_seq.
// Expected results are queued at acceptance and checked on out_valid.
module tb_lzd_norm_seq;

    typedef struct {
        logic [63:0] data;
        logic [6:0]  lzc;
        logic        zero;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [6:0]  out_lzc;
    logic        out_zero;

    int vectors = 0;
    int fails   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lzd_norm_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lzc   (out_lzc),
        .out_zero  (out_zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] d);
        exp_t e;
        int n;
        n = 64;
        for (int i = 63; i >= 0; i--) begin
            if (d[i]) begin
                n = 63 - i;
                break;
            end
        end
        e.lzc  = 7'(n);
        e.zero = (d == 64'd0);
        e.data = (n == 64) ? 64'd0 : (d << n);
        e.lat  = (d[63:32] != 0) ? 3 : ((d[31:0] != 0) ? 4 : 3);
        return e;
    endfunction

    // Offer an operand; returns once it is accepted (bounded wait).
    task automatic accept(input logic [63:0] d, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    // Wait for out_valid, check latency and popped expectation.
    task automatic collect(input string tag);
        int lat;
        exp_t e;
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(e.lat));
        check({tag, "_data"}, out_data, e.data);
        check({tag, "_lzc"}, 64'(out_lzc), 64'(e.lzc));
        check({tag, "_zero"}, 64'(out_zero), 64'(e.zero));
        step();
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic [6:0] l,
                                input logic z, input int lat);
        exp_t e;
        e.data = d;
        e.lzc  = l;
        e.zero = z;
        e.lat  = lat;
        return e;
    endfunction

    initial begin
        exp_t e;
        logic [63:0] r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset behaviour
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_lzc", 64'(out_lzc), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Directed vectors from the test plan
        accept(64'h8000_0000_0000_0000,
               mk(64'h8000_0000_0000_0000, 7'd0, 1'b0, 3));
        collect("msb");
        accept(64'h0000_0001_2345_6789,
               mk(64'h91A2_B3C4_8000_0000, 7'd31, 1'b0, 3));
        collect("hi31");
        accept(64'h0000_0000_0000_0001,
               mk(64'h8000_0000_0000_0000, 7'd63, 1'b0, 4));
        collect("lsb");
        accept(64'h0, mk(64'h0, 7'd64, 1'b1, 3));
        collect("zero");
        accept(64'h0000_0000_8000_0000,
               mk(64'h8000_0000_0000_0000, 7'd32, 1'b0, 4));
        collect("lo32");

        // Backpressure with a second operand offered during the stall
        out_ready = 1'b0;
        accept(64'h0000_0001_2345_6789,
               mk(64'h91A2_B3C4_8000_0000, 7'd31, 1'b0, 3));
        step();
        step();
        check("bp_valid_rise", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_data  = 64'h0000_00F0_0000_0000;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_data", out_data, sb[0].data);
            check("bp_lzc", 64'(out_lzc), 64'(sb[0].lzc));
            step();
        end
        e = sb.pop_front();
        out_ready = 1'b1;
        step();
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        check("bp_idle_valid", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        sb.push_back(mk(64'hF000_0000_0000_0000, 7'd24, 1'b0, 3));
        collect("bp_second");

        // Reset while the 0x1 operand sits in LO
        accept(64'h1, mk(64'h8000_0000_0000_0000, 7'd63, 1'b0, 4));
        step();
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 64'(in_ready), 64'd1);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            check("midrst_no_valid", 64'(out_valid), 64'd0);
            step();
        end
        accept(64'h4000_0000_0000_0000,
               mk(64'h8000_0000_0000_0000, 7'd1, 1'b0, 3));
        collect("after_rst");

        // Random operands of each shape against the reference model
        for (int i = 0; i < 12; i++) begin
            r = {$urandom, $urandom};
            case (i % 3)
                0: r = r >> $urandom_range(0, 31);
                1: r = {32'd0, r[31:0] >> $urandom_range(0, 31)};
                default: r = r >> $urandom_range(0, 63);
            endcase
            if (r == 64'd0) r = 64'd5;
            accept(r, model(r));
            collect("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
